// File: rtl/light_mon_pkg.sv
// light_mon_pkg: shared phase codes, lamp tuple encodings, fault codes, FSM states and dwell lookup
// Tuples are packed {m1, m2, mt, s}, each lamp encoded {red, yellow, green}.
package light_mon_pkg;
  typedef logic [2:0] phase_t;
  localparam phase_t PH_NONE = 3'd0;
  localparam phase_t PH_A    = 3'd1;
  localparam phase_t PH_B    = 3'd2;
  localparam phase_t PH_C    = 3'd3;
  localparam phase_t PH_D    = 3'd4;
  localparam phase_t PH_E    = 3'd5;
  localparam phase_t PH_F    = 3'd6;
  localparam logic [11:0] TUP_A = 12'b001_001_100_100;
  localparam logic [11:0] TUP_B = 12'b001_010_100_100;
  localparam logic [11:0] TUP_C = 12'b001_100_001_100;
  localparam logic [11:0] TUP_D = 12'b010_100_010_100;
  localparam logic [11:0] TUP_E = 12'b100_100_100_001;
  localparam logic [11:0] TUP_F = 12'b100_100_100_010;
  typedef logic [2:0] fcode_t;
  localparam fcode_t FC_NONE    = 3'd0;
  localparam fcode_t FC_ILLEGAL = 3'd1;
  localparam fcode_t FC_SEQ     = 3'd2;
  localparam fcode_t FC_SHORT   = 3'd3;
  localparam fcode_t FC_LONG    = 3'd4;
  typedef logic [1:0] state_t;
  localparam state_t ST_SYNC  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_FAULT = 2'd2;
  function automatic phase_t next_phase(input phase_t p);
    return (p == PH_F) ? PH_A : p + 3'd1;
  endfunction
  // Required dwell in cycles: one more than the configured dwell count.
  function automatic int dwell_req(input phase_t p, input int s1, input int s2, input int s3, input int s4);
    return (p == PH_A) ? s1 + 1 :
           (p == PH_B || p == PH_D) ? s2 + 1 :
           (p == PH_C) ? s3 + 1 : s4 + 1;
  endfunction
endpackage

// File: rtl/light_phase_decoder.sv
// light_phase_decoder: combinational lamp tuple -> phase decode
// Ports: tuple_i {m1,m2,mt,s}; phase_o 1..6 for A..F, 0 when illegal; valid_o high on a legal tuple.
module light_phase_decoder
  import light_mon_pkg::*;
(
  input  logic [11:0] tuple_i,
  output phase_t      phase_o,
  output logic        valid_o
);
  assign phase_o = (tuple_i == TUP_A) ? PH_A :
                   (tuple_i == TUP_B) ? PH_B :
                   (tuple_i == TUP_C) ? PH_C :
                   (tuple_i == TUP_D) ? PH_D :
                   (tuple_i == TUP_E) ? PH_E :
                   (tuple_i == TUP_F) ? PH_F : PH_NONE;
  assign valid_o = phase_o != PH_NONE;
endmodule

// File: rtl/light_conflict_monitor.sv
// light_conflict_monitor: checks observed traffic lamp drives for illegal tuples, bad sequencing and dwell violations
// Ports: clk; reset (sync, active-low); m1/m2/mt/s lamp drives {r,y,g}; clr_fault pulse;
//        phase/phase_valid decode of the registered tuple; fault sticky flag; fault_code 0 none,1 ILLEGAL,2 SEQ,3 SHORT,4 LONG.
// Build option: define MON_LONG_CHECK_EN to enable the over-long dwell (LONG) check.
module light_conflict_monitor
  import light_mon_pkg::*;
#(
  parameter int SEC1 = 7,
  parameter int SEC2 = 2,
  parameter int SEC3 = 5,
  parameter int SEC4 = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] m1,
  input  logic [2:0] m2,
  input  logic [2:0] mt,
  input  logic [2:0] s,
  input  logic       clr_fault,
  output logic [2:0] phase,
  output logic       phase_valid,
  output logic       fault,
  output logic [2:0] fault_code
);
  localparam int M12  = (SEC1 > SEC2) ? SEC1 : SEC2;
  localparam int M34  = (SEC3 > SEC4) ? SEC3 : SEC4;
  localparam int MAXS = (M12 > M34) ? M12 : M34;
  localparam int CW   = $clog2(MAXS + 3);
  localparam logic [CW-1:0] CMAX = CW'(MAXS + 2);
  logic [11:0]   tup_q;
  logic          tv_q;
  phase_t        phase_q, cur;
  logic          valid_q, cv;
  fcode_t        code_q, code_d, new_code;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, req_prev;
  logic          chg, same, f_ill, f_seq, f_short, f_long;
  light_phase_decoder u_dec (
    .tuple_i (tup_q),
    .phase_o (cur),
    .valid_o (cv)
  );
  // Phase transitions compare the freshly decoded tuple against last cycle's decoded phase.
  assign chg      = valid_q && cv && (cur != phase_q);
  assign same     = valid_q && cv && (cur == phase_q);
  assign req_prev = CW'(dwell_req(phase_q, SEC1, SEC2, SEC3, SEC4));
  // tv_q masks the cleared input register on the first edge out of reset.
  assign f_ill    = tv_q && !cv;
  assign f_seq    = (state_q != ST_FAULT) && chg && (cur != next_phase(phase_q));
  assign f_short  = (state_q == ST_RUN) && chg && (cnt_q < req_prev);
`ifdef MON_LONG_CHECK_EN
  logic [CW-1:0] req_cur;
  assign req_cur  = CW'(dwell_req(cur, SEC1, SEC2, SEC3, SEC4));
  // Counter already equals the requirement, so this cycle is the first one beyond it.
  assign f_long   = (state_q == ST_RUN) && same && (cnt_q == req_cur);
`else
  assign f_long   = 1'b0;
`endif
  always_comb begin
    new_code = f_ill ? FC_ILLEGAL : f_seq ? FC_SEQ : f_short ? FC_SHORT : f_long ? FC_LONG : FC_NONE;
    // Latched code is frozen unless cleared; a fault seen alongside the clear overrides it.
    code_d   = (state_q == ST_FAULT && !clr_fault) ? code_q : new_code;
    state_d  = (code_d != FC_NONE) ? ST_FAULT :
               (state_q == ST_FAULT) ? ST_SYNC :
               (state_q == ST_SYNC && chg) ? ST_RUN : state_q;
    cnt_d    = same ? ((cnt_q == CMAX) ? cnt_q : cnt_q + CW'(1)) : CW'(1);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      tup_q   <= '0;
      tv_q    <= 1'b0;
      phase_q <= PH_NONE;
      valid_q <= 1'b0;
      code_q  <= FC_NONE;
      state_q <= ST_SYNC;
      cnt_q   <= '0;
    end else begin
      tup_q   <= {m1, m2, mt, s};
      tv_q    <= 1'b1;
      phase_q <= cur;
      valid_q <= cv;
      code_q  <= code_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  assign phase       = phase_q;
  assign phase_valid = valid_q;
  assign fault       = state_q == ST_FAULT;
  assign fault_code  = code_q;
endmodule

// File: doc/light_conflict_monitor.md
LIGHT_CONFLICT_MONITOR -- requirements
Module: light_conflict_monitor

Interface
REQ-001 SHALL provide parameter SEC1, default 7: dwell count of phase A; A's required dwell is SEC1+1 cycles.
REQ-002 SHALL provide parameter SEC2, default 2: dwell count of phases B and D; required dwell is SEC2+1 cycles.
REQ-003 SHALL provide parameter SEC3, default 5: dwell count of phase C; required dwell is SEC3+1 cycles.
REQ-004 SHALL provide parameter SEC4, default 3: dwell count of phases E and F; required dwell is SEC4+1 cycles.
REQ-005 SHALL provide port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 SHALL provide port reset, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL provide ports m1, m2, mt, s, input, 3 bits each: observed lamp drives, encoded {red, yellow, green}.
REQ-008 SHALL provide port clr_fault, input, 1 bit: one-cycle pulse that clears a latched fault.
REQ-009 SHALL provide port phase, output, 3 bits: decoded phase of the registered tuple (A=1 through F=6, 0 = none).
REQ-010 SHALL provide port phase_valid, output, 1 bit: high when the registered tuple decodes to a legal phase.
REQ-011 SHALL provide port fault, output, 1 bit: sticky fault flag.
REQ-012 SHALL provide port fault_code, output, 3 bits: 0 none, 1 ILLEGAL, 2 SEQ, 3 SHORT, 4 LONG.

Function
REQ-013 SHALL register {m1,m2,mt,s} once per cycle and decode the registered tuple as follows (m1/m2/mt/s): A=001/001/100/100, B=001/010/100/100, C=001/100/001/100, D=010/100/010/100, E=100/100/100/001, F=100/100/100/010; any other tuple SHALL be illegal.
REQ-014 SHALL implement the states SYNC, RUN and FAULT; reset enters SYNC.
REQ-015 SYNC: SHALL count dwell without checking it; the first legal phase change to the successor phase SHALL move to RUN with the dwell counter set to 1.
REQ-016 RUN: SHALL hold a dwell counter, saturating, sized for the largest of SEC1..SEC4 plus 2, that increments each cycle the phase is unchanged.
REQ-017 ILLEGAL (code 1) SHALL be flagged in any state when the registered tuple does not decode to a legal phase.
REQ-018 SEQ (code 2) SHALL be flagged in SYNC or RUN when a legal phase changes to a phase other than its successor (A->B->C->D->E->F->A).
REQ-019 SHORT (code 3) SHALL be flagged in RUN when the phase changes with a dwell below the required dwell for the previous phase.
REQ-020 LONG (code 4) SHALL be flagged in RUN on the first cycle the dwell exceeds the required dwell for the current phase.
REQ-021 When several faults coincide, the priority SHALL be ILLEGAL > SEQ > SHORT > LONG.
REQ-022 SHALL latch the first fault: enter FAULT, hold fault=1, and freeze fault_code until cleared.
REQ-023 Latency: a tuple present on the ports in cycle k SHALL be reflected in phase, phase_valid, fault and fault_code in cycle k+2.
REQ-024 In FAULT, clr_fault SHALL return the block to SYNC with fault=0 and code 0; if a new fault is detected in the same cycle, the new fault SHALL win and remain latched.
REQ-025 clr_fault outside FAULT SHALL have no effect.

Reset
REQ-026 While reset=0 at a clock edge, the block SHALL clear the input register, counter, phase, phase_valid, fault and fault_code to 0 and enter SYNC, including mid-RUN or in FAULT.
REQ-027 SHALL begin checking on the first edge with reset=1.

Configuration
REQ-028 SHALL use the macro MON_LONG_CHECK_EN to control the LONG check.
REQ-029 With MON_LONG_CHECK_EN defined, the LONG check SHALL be as in REQ-020.
REQ-030 With MON_LONG_CHECK_EN undefined, LONG logic SHALL be absent and code 4 SHALL never be produced; a stuck phase SHALL then only be caught as SHORT or SEQ when it eventually changes.

Structure
REQ-031 The shared package light_mon_pkg SHALL hold the phase codes, the six tuple encodings, the fault codes, the state type and a dwell-lookup function.
REQ-032 SHALL use one combinational sub-module, light_phase_decoder: registered tuple -> {phase, phase_valid}.

Verification
REQ-033 Nominal sequence A8/B3/C6/D3/E4/F4 cycles, repeated twice -> fault=0 throughout and phase steps 1..6, with RUN entered after the first change.
REQ-034 In RUN, m1=011 for one cycle -> two cycles later fault=1, code=1 and phase_valid=0; the fault stays latched.
REQ-035 A held 8 cycles, then the C tuple -> code 2.
REQ-036 In RUN, C held 4 cycles then D -> code 3; with MON_LONG_CHECK_EN, E held 5 cycles -> code 4 on its 5th cycle; without the macro, no fault.
REQ-037 With fault latched, a clr_fault pulse with a legal tuple -> fault=0 and state SYNC; clr_fault in the same cycle as an illegal tuple -> code 1 remains latched.
REQ-038 reset=0 asserted mid-RUN -> all outputs 0 at the next edge; after release, the nominal sequence -> no fault.
